id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Instruction-decode stage plus ID/EX pipeline register of the 5-stage MIPS32 core.
- Drives register-file read addresses from the IF/ID instruction and takes the async read data.
- Bypasses same-cycle WB writes, decodes control, detects load-use hazards (stall plus bubble) and honours EX branch flushes.
- Feeds the EX stage.

Parameters:
- DATA_W, 32, datapath width.
- ALUOP_W, 4, width of the ALU operation code.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- if_id_valid  in  1  IF/ID holds a real instruction.
- if_id_instr  in  32  instruction word.
- if_id_pc4  in  32  PC+4 of the instruction.
- ReadRegister1  out  5  regfile rs address, equal to instr[25:21].
- ReadRegister2  out  5  regfile rt address, equal to instr[20:16].
- ReadData1  in  32  regfile rs data.
- ReadData2  in  32  regfile rt data.
- wb_RegWrite  in  1  WB write enable, for bypass.
- wb_WriteRegister  in  5  WB destination register.
- wb_WriteData  in  32  WB data.
- flush  in  1  EX branch/jump taken; squash ID.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc4  out  32  registered PC+4.
- ex_rs_data  out  32  registered rs operand.
- ex_rt_data  out  32  registered rt operand.
- ex_imm  out  32  registered extended immediate.
- ex_rs  out  5  registered rs field.
- ex_rt  out  5  registered rt field.
- ex_dst  out  5  resolved destination (rd for R-type, rt for I-type).
- ex_shamt  out  5  registered shift amount.
- ex_ctrl  out  8  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, BranchNe, Illegal}.
- ex_aluop  out  ALUOP_W  ALU operation code.
- stall_count  out  32  load-use stall counter (see Optional Feature).

Behaviour:
- Reset (async): every registered output is 0. ex_valid=0. stall_count=0.
- Read addresses are combinational from if_id_instr, regardless of valid.
- Bypass: if wb_RegWrite, and wb_WriteRegister != 0, and wb_WriteRegister equals rs (or rt), the operand is wb_WriteData; otherwise ReadData1/2. The bypass decision is combinational, ahead of the ID/EX flop.
- Decode set:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra.
  - I-type: addi, addiu, slti, andi, ori, xori, lui, lw, sw, beq, bne.
  - Anything else: all ctrl bits 0 except Illegal=1; ex_valid still follows if_id_valid.
- Immediate:
  - Sign-extend for addi, addiu, slti, lw, sw, beq, bne.
  - Zero-extend for andi, ori, xori.
  - lui: {imm16, 16'h0}.
  - R-type: 0.
- uses_rs: every decoded op except sll/srl/sra and lui.
- uses_rt: R-type, sw, beq, bne.
- Load-use hazard, evaluated every cycle (combinational):
  - haz = if_id_valid AND ex_valid AND ex MemRead AND ex_rt != 0 AND ((uses_rs AND ex_rt == rs) OR (uses_rt AND ex_rt == rt)).
- Per-edge priority:
  - flush=1: ex_valid<=0 and ex_ctrl<=0; data flops don't-care (hold).
  - Otherwise, if haz: ex_valid<=0 and ex_ctrl<=0 (bubble); stall=1.
  - Otherwise: capture decode, ex_valid<=if_id_valid. If if_id_valid=0, ex_ctrl<=0.
- stall = haz AND NOT flush. A hazard stall lasts exactly one cycle, because the bubble clears ex MemRead.
- Latency: 1 cycle from IF/ID to ID/EX outputs.
- Writes to register 0 are never bypassed. rs=0 or rt=0 never triggers a hazard.
- Reset mid-stall: stall drops immediately (ex_valid=0).

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined: stall_count increments by 1 on each clock edge where stall=1. It wraps from 0xFFFFFFFF to 0. Cleared by reset.
- Undefined: stall_count is tied to 0 and no counter flops exist.

Decomposition:
- Package (mips_defines): opcode/funct constants, ALUOP encodings, ex_ctrl bit indices.
- Sub-module mips_ctrl_decode: pure combinational instr -> ctrl, aluop, imm-extend select, uses_rs, uses_rt, RegDst.
- id_ex_stage holds the bypass, hazard logic and flops.

Test Plan:
- Decode: add $3,$1,$2 with rs=5, rt=7 -> next cycle ex_rs_data=5, ex_rt_data=7, ex_dst=3, RegWrite=1, ALUSrc=0, ex_valid=1.
- Immediate: addi imm=0xFFF0 -> ex_imm=0xFFFFFFF0. ori imm=0xFFF0 -> 0x0000FFF0. lui 0x1234 -> 0x12340000.
- Bypass: wb writes $8=0xCAFE0001 while ID reads rs=$8 and regfile returns a stale 0x10 -> ex_rs_data=0xCAFE0001. Same stimulus with WriteRegister=0 -> no bypass.
- Load-use: lw $9 followed by add $10,$9,$1 -> stall=1 for exactly 1 cycle, a bubble (ex_valid=0), then add captured. stall_count=1 when ID_STALL_CNT_EN is defined, 0 otherwise.
- Flush priority: flush=1 in the same cycle as a load-use hazard -> stall=0, ex_valid=0 next cycle.
- Illegal: opcode 0x3F with if_id_valid=1 -> ex_valid=1, Illegal=1, all other ctrl bits 0. Async reset asserted mid-operation -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/mips_defines.sv
// mips_defines: opcode/funct constants, ALU op encodings, ex_ctrl layout and
// immediate-extension selector shared by the decode stage.
package mips_defines;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_BEQ   = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B, F_SLL = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
    // ex_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, BranchNe, Illegal}
    localparam int CTRL_REGWRITE = 7, CTRL_MEMREAD = 6, CTRL_MEMWRITE = 5, CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC = 3, CTRL_BRANCH = 2, CTRL_BRANCHNE = 1, CTRL_ILLEGAL = 0;
    localparam logic [7:0] C_RTYPE = 8'b1000_0000, C_ALUI = 8'b1000_1000, C_LW  = 8'b1101_1000;
    localparam logic [7:0] C_SW    = 8'b0010_1000, C_BEQ  = 8'b0000_0100, C_BNE = 8'b0000_0010;
    localparam logic [7:0] C_ILL   = 8'b0000_0001;
    typedef enum logic [1:0] {IMM_ZERO, IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_sel_e;
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: opcode/funct -> control bits, ALU op, immediate form,
// operand usage and destination select. Purely combinational.
module mips_ctrl_decode
    import mips_defines::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [5:0]         op_i,
    input  logic [5:0]         funct_i,
    output logic [7:0]         ctrl_o,
    output logic [ALUOP_W-1:0] aluop_o,
    output imm_sel_e           imm_sel_o,
    output logic               uses_rs_o,
    output logic               uses_rt_o,
    output logic               reg_dst_o
);
    logic [3:0] r_alu, alu;
    logic       r_ok, shift;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (funct_i)
            F_ADD, F_ADDU: r_alu = ALU_ADD;
            F_SUB, F_SUBU: r_alu = ALU_SUB;
            F_AND:         r_alu = ALU_AND;
            F_OR:          r_alu = ALU_OR;
            F_XOR:         r_alu = ALU_XOR;
            F_NOR:         r_alu = ALU_NOR;
            F_SLT:         r_alu = ALU_SLT;
            F_SLTU:        r_alu = ALU_SLTU;
            F_SLL:         r_alu = ALU_SLL;
            F_SRL:         r_alu = ALU_SRL;
            F_SRA:         r_alu = ALU_SRA;
            default:       r_ok  = 1'b0;
        endcase
    end

    assign shift   = funct_i inside {F_SLL, F_SRL, F_SRA};
    assign aluop_o = ALUOP_W'(alu);

    always_comb begin
        ctrl_o    = C_ILL;
        alu       = ALU_ADD;
        imm_sel_o = IMM_ZERO;
        uses_rs_o = 1'b1;
        uses_rt_o = 1'b0;
        reg_dst_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                ctrl_o    = r_ok ? C_RTYPE : C_ILL;
                alu       = r_alu;
                uses_rs_o = r_ok && !shift;
                uses_rt_o = r_ok;
                reg_dst_o = r_ok;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                ctrl_o    = C_ALUI;
                alu       = op_i == OP_SLTI ? ALU_SLT : ALU_ADD;
                imm_sel_o = IMM_SEXT;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_o    = C_ALUI;
                alu       = op_i == OP_ANDI ? ALU_AND : op_i == OP_ORI ? ALU_OR : ALU_XOR;
                imm_sel_o = IMM_ZEXT;
            end
            OP_LUI: begin
                ctrl_o    = C_ALUI;
                alu       = ALU_LUI;
                imm_sel_o = IMM_LUI;
                uses_rs_o = 1'b0;
            end
            OP_LW, OP_SW: begin
                ctrl_o    = op_i == OP_LW ? C_LW : C_SW;
                imm_sel_o = IMM_SEXT;
                uses_rt_o = op_i == OP_SW;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o    = op_i == OP_BEQ ? C_BEQ : C_BNE;
                alu       = ALU_SUB;
                imm_sel_o = IMM_SEXT;
                uses_rt_o = 1'b1;
            end
            default: uses_rs_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS32 decode stage and ID/EX register with WB bypass, load-use stall
// and flush. Define ID_STALL_CNT_EN to count load-use stall cycles on stall_count.
module id_ex_stage
    import mips_defines::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_id_valid,
    input  logic [31:0]        if_id_instr,
    input  logic [31:0]        if_id_pc4,
    output logic [4:0]         ReadRegister1,
    output logic [4:0]         ReadRegister2,
    input  logic [DATA_W-1:0]  ReadData1,
    input  logic [DATA_W-1:0]  ReadData2,
    input  logic               wb_RegWrite,
    input  logic [4:0]         wb_WriteRegister,
    input  logic [DATA_W-1:0]  wb_WriteData,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic [31:0]        ex_pc4,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_dst,
    output logic [4:0]         ex_shamt,
    output logic [7:0]         ex_ctrl,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [31:0]        stall_count
);
    logic [4:0]         rs, rt, dst_d;
    logic [15:0]        imm16;
    logic [7:0]         dec_ctrl, ctrl_d, ctrl_q;
    logic [ALUOP_W-1:0] dec_aluop, aluop_q;
    imm_sel_e           imm_sel;
    logic               uses_rs, uses_rt, reg_dst, haz, cap, valid_d, valid_q;
    logic [DATA_W-1:0]  rs_data_d, rt_data_d, imm_d, rs_data_q, rt_data_q, imm_q;
    logic [31:0]        pc4_q;
    logic [4:0]         rs_q, rt_q, dst_q, shamt_q;

    assign rs    = if_id_instr[25:21];
    assign rt    = if_id_instr[20:16];
    assign imm16 = if_id_instr[15:0];
    assign ReadRegister1 = rs;
    assign ReadRegister2 = rt;

    mips_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_dec (
        .op_i      (if_id_instr[31:26]),
        .funct_i   (if_id_instr[5:0]),
        .ctrl_o    (dec_ctrl),
        .aluop_o   (dec_aluop),
        .imm_sel_o (imm_sel),
        .uses_rs_o (uses_rs),
        .uses_rt_o (uses_rt),
        .reg_dst_o (reg_dst)
    );

    // Same-cycle WB write wins over the stale regfile read; $0 is never forwarded.
    assign rs_data_d = (wb_RegWrite && wb_WriteRegister != 5'd0 && wb_WriteRegister == rs) ? wb_WriteData : ReadData1;
    assign rt_data_d = (wb_RegWrite && wb_WriteRegister != 5'd0 && wb_WriteRegister == rt) ? wb_WriteData : ReadData2;
    assign dst_d     = reg_dst ? if_id_instr[15:11] : rt;
    assign imm_d     = imm_sel == IMM_SEXT ? {{(DATA_W-16){imm16[15]}}, imm16}
                     : imm_sel == IMM_ZEXT ? {{(DATA_W-16){1'b0}}, imm16}
                     : imm_sel == IMM_LUI  ? {imm16, {(DATA_W-16){1'b0}}} : '0;

    assign haz   = if_id_valid && valid_q && ctrl_q[CTRL_MEMREAD] && rt_q != 5'd0 &&
                   ((uses_rs && rt_q == rs) || (uses_rt && rt_q == rt));
    assign stall = haz && !flush;
    assign cap   = !flush && !haz;

    assign valid_d = cap && if_id_valid;
    assign ctrl_d  = valid_d ? dec_ctrl : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            shamt_q   <= '0;
            aluop_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            if (cap) begin
                pc4_q     <= if_id_pc4;
                rs_data_q <= rs_data_d;
                rt_data_q <= rt_data_d;
                imm_q     <= imm_d;
                rs_q      <= rs;
                rt_q      <= rt;
                dst_q     <= dst_d;
                shamt_q   <= if_id_instr[10:6];
                aluop_q   <= dec_aluop;
            end
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_pc4     = pc4_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm     = imm_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_dst     = dst_q;
    assign ex_shamt   = shamt_q;
    assign ex_aluop   = aluop_q;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed + random stimulus against a mnemonic-level reference model,
// registered outputs checked by a scoreboard monitor on the falling edge.
module tb_id_ex_stage;
    import mips_defines::*;

`ifdef ID_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        if_id_valid = 1'b0, wb_RegWrite = 1'b0, flush = 1'b0;
    logic [31:0] if_id_instr = '0, if_id_pc4 = '0, wb_WriteData = '0;
    logic [4:0]  wb_WriteRegister = '0;
    logic [4:0]  ReadRegister1, ReadRegister2, ex_rs, ex_rt, ex_dst, ex_shamt;
    logic [31:0] ReadData1, ReadData2, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, stall_count;
    logic        stall, ex_valid;
    logic [7:0]  ex_ctrl;
    logic [3:0]  ex_aluop;
    logic [31:0] regs [32];

    always #5 clk = ~clk;

    assign ReadData1 = regs[ReadRegister1];
    assign ReadData2 = regs[ReadRegister2];

    id_ex_stage dut (
        .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .wb_RegWrite(wb_RegWrite),
        .wb_WriteRegister(wb_WriteRegister), .wb_WriteData(wb_WriteData), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_shamt(ex_shamt), .ex_ctrl(ex_ctrl), .ex_aluop(ex_aluop), .stall_count(stall_count)
    );

    typedef enum {M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                  M_SLL, M_SRL, M_SRA, M_ADDI, M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI,
                  M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_ILL} mn_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dst, shamt;
        logic [7:0]  ctrl;
        logic [3:0]  aluop;
        logic [31:0] cnt;
    } st_t;

    localparam bit [5:0] OPS [12] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    localparam bit [5:0] FNS [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    st_t m, e;
    st_t q[$];
    int  n_tests = 0, n_fail = 0;

    function automatic mn_e mnem(input logic [31:0] i);
        mn_e r = M_ILL;
        case (i[31:26])
            6'h00: case (i[5:0])
                6'h20: r = M_ADD;  6'h21: r = M_ADDU; 6'h22: r = M_SUB; 6'h23: r = M_SUBU;
                6'h24: r = M_AND;  6'h25: r = M_OR;   6'h26: r = M_XOR; 6'h27: r = M_NOR;
                6'h2A: r = M_SLT;  6'h2B: r = M_SLTU; 6'h00: r = M_SLL; 6'h02: r = M_SRL;
                6'h03: r = M_SRA;  default: r = M_ILL;
            endcase
            6'h08: r = M_ADDI; 6'h09: r = M_ADDIU; 6'h0A: r = M_SLTI; 6'h0C: r = M_ANDI;
            6'h0D: r = M_ORI;  6'h0E: r = M_XORI;  6'h0F: r = M_LUI;  6'h23: r = M_LW;
            6'h2B: r = M_SW;   6'h04: r = M_BEQ;   6'h05: r = M_BNE;
            default: r = M_ILL;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] ctrl_of(input mn_e k);
        return {k <= M_SRA || (k >= M_ADDI && k <= M_LW), k == M_LW, k == M_SW, k == M_LW,
                k >= M_ADDI && k <= M_SW, k == M_BEQ, k == M_BNE, k == M_ILL};
    endfunction

    function automatic logic [3:0] aluop_of(input mn_e k);
        case (k)
            M_SUB, M_SUBU, M_BEQ, M_BNE: return ALU_SUB;
            M_AND, M_ANDI:               return ALU_AND;
            M_OR, M_ORI:                 return ALU_OR;
            M_XOR, M_XORI:               return ALU_XOR;
            M_NOR:                       return ALU_NOR;
            M_SLT, M_SLTI:               return ALU_SLT;
            M_SLTU:                      return ALU_SLTU;
            M_SLL:                       return ALU_SLL;
            M_SRL:                       return ALU_SRL;
            M_SRA:                       return ALU_SRA;
            M_LUI:                       return ALU_LUI;
            default:                     return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input mn_e k, input logic [15:0] v);
        if (k inside {M_ADDI, M_ADDIU, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE}) return {{16{v[15]}}, v};
        if (k inside {M_ANDI, M_ORI, M_XORI}) return {16'h0, v};
        if (k == M_LUI) return {v, 16'h0};
        return 32'h0;
    endfunction

    function automatic logic uses_rs_of(input mn_e k);
        return !(k inside {M_SLL, M_SRL, M_SRA, M_LUI, M_ILL});
    endfunction

    function automatic logic uses_rt_of(input mn_e k);
        return k <= M_SRA || k inside {M_SW, M_BEQ, M_BNE};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s, t, d);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] v);
        return {op, s, t, v};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op;
        logic [31:0] r;
        op = $urandom_range(0, 3) == 0 ? 6'h23 : OPS[$urandom_range(0, 11)];
        if ($urandom_range(0, 15) == 0) op = 6'($urandom);
        r = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        if (op == 6'h00) r[5:0] = $urandom_range(0, 7) == 0 ? 6'($urandom) : FNS[$urandom_range(0, 12)];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " stall"}, 32'(stall), 32'h0);
        chk({tag, " ex_valid"}, 32'(ex_valid), 32'h0);
        chk({tag, " ex_ctrl"}, 32'(ex_ctrl), 32'h0);
        chk({tag, " ex_pc4"}, ex_pc4, 32'h0);
        chk({tag, " ex_rs_data"}, ex_rs_data, 32'h0);
        chk({tag, " ex_rt_data"}, ex_rt_data, 32'h0);
        chk({tag, " ex_imm"}, ex_imm, 32'h0);
        chk({tag, " ex_fields"}, {12'h0, ex_rs, ex_rt, ex_dst, ex_shamt}, 32'h0);
        chk({tag, " ex_aluop"}, 32'(ex_aluop), 32'h0);
        chk({tag, " stall_count"}, stall_count, 32'h0);
    endtask

    // Called just after a rising edge; applies one cycle of inputs and predicts the next state.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ww, input logic [4:0] wr, input logic [31:0] wd, input logic fl);
        mn_e        k;
        logic [4:0] s, t;
        logic       haz, stl;
        st_t        n;
        if_id_valid = v; if_id_instr = ins; if_id_pc4 = pc;
        wb_RegWrite = ww; wb_WriteRegister = wr; wb_WriteData = wd; flush = fl;
        #1;
        k = mnem(ins);
        s = ins[25:21];
        t = ins[20:16];
        chk("ReadRegister1", 32'(ReadRegister1), 32'(s));
        chk("ReadRegister2", 32'(ReadRegister2), 32'(t));
        haz = v && m.valid && m.ctrl[6] && m.rt != 5'd0 &&
              ((uses_rs_of(k) && m.rt == s) || (uses_rt_of(k) && m.rt == t));
        stl = haz && !fl;
        chk("stall", 32'(stall), 32'(stl));
        n = m;
        if (fl || haz) begin
            n.valid = 1'b0;
            n.ctrl  = '0;
        end else begin
            n.valid   = v;
            n.ctrl    = v ? ctrl_of(k) : 8'h0;
            n.pc4     = pc;
            n.rs_data = (ww && wr != 0 && wr == s) ? wd : regs[s];
            n.rt_data = (ww && wr != 0 && wr == t) ? wd : regs[t];
            n.imm     = imm_of(k, ins[15:0]);
            n.rs      = s;
            n.rt      = t;
            n.dst     = k <= M_SRA ? ins[15:11] : t;
            n.shamt   = ins[10:6];
            n.aluop   = aluop_of(k);
        end
        if (stl && CNT_EN) n.cnt = m.cnt + 1;
        @(posedge clk);
        m = n;
        q.push_back(n);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("ex_valid", 32'(ex_valid), 32'(e.valid));
            chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
            chk("ex_pc4", ex_pc4, e.pc4);
            chk("ex_rs_data", ex_rs_data, e.rs_data);
            chk("ex_rt_data", ex_rt_data, e.rt_data);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_rs", 32'(ex_rs), 32'(e.rs));
            chk("ex_rt", 32'(ex_rt), 32'(e.rt));
            chk("ex_dst", 32'(ex_dst), 32'(e.dst));
            chk("ex_shamt", 32'(ex_shamt), 32'(e.shamt));
            chk("ex_aluop", 32'(ex_aluop), 32'(e.aluop));
            chk("stall_count", stall_count, e.cnt);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[8] = 32'h10;
        m = '0;
        @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        step(1, enc_r(F_ADD, 5'd1, 5'd2, 5'd3), 32'h104, 0, 0, 0, 0);
        step(1, enc_i(OP_ADDI, 5'd1, 5'd4, 16'hFFF0), 32'h108, 0, 0, 0, 0);
        step(1, enc_i(OP_ORI, 5'd1, 5'd4, 16'hFFF0), 32'h10C, 0, 0, 0, 0);
        step(1, enc_i(OP_LUI, 5'd0, 5'd5, 16'h1234), 32'h110, 0, 0, 0, 0);
        step(1, enc_r(F_ADD, 5'd8, 5'd2, 5'd9), 32'h114, 1, 5'd8, 32'hCAFE0001, 0);
        step(1, enc_r(F_ADD, 5'd0, 5'd8, 5'd9), 32'h118, 1, 5'd0, 32'hCAFE0001, 0);
        step(1, enc_r(F_ADD, 5'd8, 5'd8, 5'd9), 32'h11C, 0, 5'd8, 32'hCAFE0001, 0);
        step(1, enc_i(OP_LW, 5'd1, 5'd9, 16'h0004), 32'h120, 0, 0, 0, 0);
        step(1, enc_r(F_ADD, 5'd9, 5'd1, 5'd10), 32'h124, 0, 0, 0, 0);
        step(1, enc_r(F_ADD, 5'd9, 5'd1, 5'd10), 32'h124, 0, 0, 0, 0);
        step(1, enc_i(OP_LW, 5'd1, 5'd9, 16'h0008), 32'h128, 0, 0, 0, 0);
        step(1, enc_r(F_ADD, 5'd9, 5'd1, 5'd10), 32'h12C, 0, 0, 0, 1);
        step(1, enc_i(6'h3F, 5'd3, 5'd4, 16'h5555), 32'h130, 0, 0, 0, 0);
        step(1, enc_i(OP_LW, 5'd0, 5'd0, 16'h0010), 32'h134, 0, 0, 0, 0);
        step(1, enc_r(F_SLL, 5'd0, 5'd0, 5'd6), 32'h138, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) != 0, rand_instr(), $urandom, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) == 0);
        step(1, enc_i(OP_LW, 5'd1, 5'd9, 16'h0004), 32'h200, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if_id_instr = enc_r(F_ADD, 5'd9, 5'd1, 5'd10);
        flush = 1'b0;
        #1;
        chk("stall before reset", 32'(stall), 32'h1);
        reset = 1'b1;
        #1;
        chk_zero("async reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        m = '0;
        step(1, enc_i(OP_LW, 5'd1, 5'd9, 16'h0004), 32'h300, 0, 0, 0, 0);
        step(1, enc_r(F_ADD, 5'd1, 5'd9, 5'd10), 32'h304, 0, 0, 0, 0);
        step(1, enc_r(F_ADD, 5'd1, 5'd9, 5'd10), 32'h304, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
